fibre_a_mem_responder: RTL

FIBRE_A_MEM_RESPONDER -- requirements
Module: fibre_a_mem_responder

---
 rtl/tppe_pkg.sv | 13 +
 rtl/fibre_a_mem_responder_if.sv | 30 +++
 rtl/fibre_rd_pipe.sv | 44 ++++
 rtl/fibre_a_mem_responder.sv | 106 ++++++++++
 4 files changed

// File: rtl/tppe_pkg.sv
// Shared types and limits for the fibre A memory responder.
package tppe_pkg;

   typedef enum logic [1:0] {
      StEmpty   = 2'd0,
      StLoading = 2'd1,
      StReady   = 2'd2
   } mem_state_e;

   localparam int unsigned ReadLatencyMin = 1;
   localparam int unsigned ReadLatencyMax = 4;

endpackage

// File: rtl/fibre_a_mem_responder_if.sv
// Host write / load control and accumulator read bundle for the fibre A responder.
interface fibre_a_mem_responder_if #(
   parameter int unsigned TIMESTEPS  = 8,
   parameter int unsigned ADDR_WIDTH = 8
);

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [TIMESTEPS-1:0]  wr_data;
   logic                  load_start;
   logic                  load_done;
   logic [ADDR_WIDTH-1:0] fibre_a_addr;
   logic                  fibre_a_read_en;
   logic [TIMESTEPS-1:0]  fibre_a_data;
   logic                  fibre_a_valid;
   logic                  rd_err;
   logic                  mem_ready;
   logic [15:0]           rd_count;

   modport master (
      output wr_en, wr_addr, wr_data, load_start, load_done, fibre_a_addr, fibre_a_read_en,
      input  fibre_a_data, fibre_a_valid, rd_err, mem_ready, rd_count
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, load_start, load_done, fibre_a_addr, fibre_a_read_en,
      output fibre_a_data, fibre_a_valid, rd_err, mem_ready, rd_count
   );

endinterface

// File: rtl/fibre_rd_pipe.sv
// Fixed-latency delay line for read responses; data and err are zero in empty slots.
module fibre_rd_pipe #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic             err_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic             err_o,
   output logic [WIDTH-1:0] data_o
);

   logic [LATENCY-1:0] valid_q;
   logic [LATENCY-1:0] err_q;
   logic [WIDTH-1:0]   data_q [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int i = 0; i < int'(LATENCY); i++) begin
            data_q[i] <= '0;
         end
      end else begin
         // Gate payload on entry so idle slots always carry zero.
         valid_q[0] <= valid_i;
         err_q[0]   <= valid_i & err_i;
         data_q[0]  <= valid_i ? data_i : '0;
         for (int i = 1; i < int'(LATENCY); i++) begin
            valid_q[i] <= valid_q[i-1];
            err_q[i]   <= err_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[LATENCY-1];
   assign err_o   = err_q[LATENCY-1];
   assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/fibre_a_mem_responder.sv
// Spike-word store loaded by a host and read by the fibre A accumulator with fixed latency.
module fibre_a_mem_responder
   import tppe_pkg::*;
#(
   parameter int unsigned TIMESTEPS    = 8,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   fibre_a_mem_responder_if.slave  bus_io
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   if (READ_LATENCY < ReadLatencyMin || READ_LATENCY > ReadLatencyMax) begin : g_bad_latency
      $error("READ_LATENCY out of range");
   end

   mem_state_e           state_q;
   logic                 mem_ready_q;
   logic [15:0]          rd_count_q;
   logic [TIMESTEPS-1:0] mem_q [Depth];

   logic                 wr_accept;
   logic                 rd_ok;
   logic                 rd_hit;
   logic [TIMESTEPS-1:0] rd_word;
   logic                 pipe_valid;
   logic                 pipe_err;
   logic [TIMESTEPS-1:0] pipe_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StEmpty;
         mem_ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            StEmpty, StReady: begin
               if (bus_io.load_start) begin
                  state_q     <= StLoading;
                  mem_ready_q <= 1'b0;
               end
            end
            StLoading: begin
               if (bus_io.load_done) begin
                  state_q     <= StReady;
                  mem_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= StEmpty;
               mem_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign wr_accept = bus_io.wr_en && (state_q != StEmpty);

   // Array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[bus_io.wr_addr] <= bus_io.wr_data;
      end
   end

   // Response is fixed at request time; same-cycle write wins.
   always_comb begin
      rd_ok   = (state_q == StReady);
      rd_hit  = wr_accept && (bus_io.wr_addr == bus_io.fibre_a_addr);
      rd_word = '0;
      if (rd_ok) begin
         rd_word = rd_hit ? bus_io.wr_data : mem_q[bus_io.fibre_a_addr];
      end
   end

   fibre_rd_pipe #(
      .WIDTH   (TIMESTEPS),
      .LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (bus_io.fibre_a_read_en),
      .err_i   (!rd_ok),
      .data_i  (rd_word),
      .valid_o (pipe_valid),
      .err_o   (pipe_err),
      .data_o  (pipe_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count_q <= '0;
      end else if (pipe_valid && !pipe_err && (rd_count_q != 16'hFFFF)) begin
         rd_count_q <= rd_count_q + 16'd1;
      end
   end

   assign bus_io.fibre_a_valid = pipe_valid;
   assign bus_io.rd_err        = pipe_err;
   assign bus_io.fibre_a_data  = pipe_data;
   assign bus_io.mem_ready     = mem_ready_q;
   assign bus_io.rd_count      = rd_count_q;

endmodule
